// File: rtl/shift_compute_driver_if.sv
// Request and tile-pin bundle for shift_compute_driver; master = requester/tile side, slave = driver.
interface shift_compute_driver_if;
  logic       start;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       op_and;
  logic [7:0] result_in;
  logic       ser_out;
  logic [2:0] sel;
  logic       add_strobe;
  logic       and_strobe;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [7:0] result_and;

  modport master (
    output start, op_a, op_b, op_and, result_in,
    input  ser_out, sel, add_strobe, and_strobe, busy, done, result, result_and
  );

  modport slave (
    input  start, op_a, op_b, op_and, result_in,
    output ser_out, sel, add_strobe, and_strobe, busy, done, result, result_and
  );
endinterface

// File: rtl/shift_compute_driver.sv
// Serial shift/compute tile sequencer: 16 shift cycles, one strobe cycle, SAMPLE_DELAY+1 wait, done at E(18+SAMPLE_DELAY).
// start is ignored while busy (no queueing); SHIFT_COMPUTE_BOTH_EN runs add and and back-to-back into result/result_and.
module shift_compute_driver #(
  parameter int SAMPLE_DELAY = 1
) (
  input logic                  clk,
  input logic                  rst,
  shift_compute_driver_if.slave bus
);

  localparam int WW = (SAMPLE_DELAY > 0) ? $clog2(SAMPLE_DELAY + 1) : 1;
  localparam logic [WW-1:0] WLAST = WW'(SAMPLE_DELAY);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_STROBE, S_WAIT} state_t;

  typedef struct packed {
    logic [15:0] word;
    logic        op_and;
  } req_t;

  state_t        state_q, state_d;
  req_t          req_q, req_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          ser_out_q, ser_out_d;
  logic [2:0]    sel_q, sel_d;
  logic          add_q, add_d;
  logic          and_q, and_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    result_q, result_d;
`ifdef SHIFT_COMPUTE_BOTH_EN
  logic          phase_q, phase_d;
  logic [7:0]    result_and_q, result_and_d;
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    ser_out_d = ser_out_q;
    sel_d     = sel_q;
    add_d     = 1'b0;
    and_d     = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
`ifdef SHIFT_COMPUTE_BOTH_EN
    phase_d      = phase_q;
    result_and_d = result_and_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          req_d.word   = {bus.op_a, bus.op_b};
          req_d.op_and = bus.op_and;
          ser_out_d    = bus.op_a[7];
          cnt_d        = 4'd0;
          busy_d       = 1'b1;
          state_d      = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q == 4'd15) begin
          ser_out_d = 1'b0;
`ifdef SHIFT_COMPUTE_BOTH_EN
          add_d     = 1'b1;
          and_d     = 1'b1;
`else
          add_d     = ~req_q.op_and;
          and_d     = req_q.op_and;
`endif
          state_d   = S_STROBE;
        end else begin
          // ser_out already shows word[15-cnt]; load the next bit down
          cnt_d     = cnt_q + 4'd1;
          ser_out_d = req_q.word[4'd14 - cnt_q];
        end
      end
      S_STROBE: begin
`ifdef SHIFT_COMPUTE_BOTH_EN
        sel_d   = 3'b100;
        phase_d = 1'b0;
`else
        sel_d   = req_q.op_and ? 3'b101 : 3'b100;
`endif
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == WLAST) begin
`ifdef SHIFT_COMPUTE_BOTH_EN
          if (!phase_q) begin
            result_d = bus.result_in;
            sel_d    = 3'b101;
            phase_d  = 1'b1;
            wcnt_d   = '0;
          end else begin
            result_and_d = bus.result_in;
            sel_d        = 3'b000;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            state_d      = S_IDLE;
          end
`else
          result_d = bus.result_in;
          sel_d    = 3'b000;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
`endif
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      cnt_q     <= 4'd0;
      wcnt_q    <= '0;
      ser_out_q <= 1'b0;
      sel_q     <= 3'b000;
      add_q     <= 1'b0;
      and_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 8'h00;
`ifdef SHIFT_COMPUTE_BOTH_EN
      phase_q      <= 1'b0;
      result_and_q <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      ser_out_q <= ser_out_d;
      sel_q     <= sel_d;
      add_q     <= add_d;
      and_q     <= and_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
`ifdef SHIFT_COMPUTE_BOTH_EN
      phase_q      <= phase_d;
      result_and_q <= result_and_d;
`endif
    end
  end

  assign bus.ser_out    = ser_out_q;
  assign bus.sel        = sel_q;
  assign bus.add_strobe = add_q;
  assign bus.and_strobe = and_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
`ifdef SHIFT_COMPUTE_BOTH_EN
  assign bus.result_and = result_and_q;
`else
  assign bus.result_and = 8'h00;
`endif

endmodule

// File: tb/tb_shift_compute_driver.sv
// Bench: behavioural tile + random/directed requests, scoreboard of expected transactions checked every cycle.
module tb_shift_compute_driver;
  localparam int SD = 1;
`ifdef SHIFT_COMPUTE_BOTH_EN
  localparam bit BOTH = 1'b1;
  localparam int L    = 19 + 2 * SD;
`else
  localparam bit BOTH = 1'b0;
  localparam int L    = 18 + SD;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_compute_driver_if bus ();
  shift_compute_driver #(.SAMPLE_DELAY(SD)) dut (.clk(clk), .rst(rst), .bus(bus));

  // behavioural tile: shifts ser_out every edge, captures on strobes, muxes uo_out by sel
  logic [15:0] tile_sr  = 16'h0;
  logic [7:0]  tile_add = 8'h0;
  logic [7:0]  tile_and = 8'h0;
  always @(posedge clk) begin
    tile_sr <= {tile_sr[14:0], bus.ser_out};
    if (bus.add_strobe) tile_add <= tile_sr[15:8] + tile_sr[7:0];
    if (bus.and_strobe) tile_and <= tile_sr[15:8] & tile_sr[7:0];
  end
  assign bus.result_in = (bus.sel == 3'b100) ? tile_add :
                         (bus.sel == 3'b101) ? tile_and : tile_sr[7:0];

  typedef struct {
    int         acc;
    logic [7:0] a;
    logic [7:0] b;
    bit         op;
    logic [7:0] res;
    logic [7:0] res_and;
  } txn_t;

  txn_t       q[$];
  int         cyc = 0;
  int         free_edge = 0;
  int         total = 0;
  int         bad = 0;
  logic [7:0] held_res = 8'h00;
  logic [7:0] held_and = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d t=%0t", nm, act, exp, cyc, $time);
    end
  endtask

  // one call sets the inputs seen at the next rising edge
  task automatic drive(input bit s, input logic [7:0] a, input logic [7:0] b, input bit op);
    txn_t t;
    @(negedge clk);
    #1;
    bus.start  = s;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.op_and = op;
    if (s && !rst && (cyc + 1 >= free_edge)) begin
      t.acc = cyc + 1;
      t.a   = a;
      t.b   = b;
      t.op  = op;
      if (BOTH) begin
        t.res     = 8'((int'(a) + int'(b)) % 256);
        t.res_and = a & b;
      end else begin
        t.res     = op ? (a & b) : 8'((int'(a) + int'(b)) % 256);
        t.res_and = 8'h00;
      end
      q.push_back(t);
      free_edge = t.acc + L + 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ser"}, bus.ser_out, 0);
    chk({tag, "_sel"}, bus.sel, 0);
    chk({tag, "_add"}, bus.add_strobe, 0);
    chk({tag, "_and"}, bus.and_strobe, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_res"}, bus.result, 0);
    chk({tag, "_resand"}, bus.result_and, 0);
  endtask

  task automatic async_reset();
    #3;
    rst = 1'b1;
    bus.start = 1'b0;
    #1;
    chk_all_zero("async_rst");
    q.delete();
    free_edge = 0;
    held_res  = 8'h00;
    held_and  = 8'h00;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  // monitor: expected pin activity is derived from the oldest outstanding request
  always @(negedge clk) begin
    txn_t        f;
    int          k;
    bit          have;
    logic [15:0] w;
    int          es;
    if (!rst) begin
      have = (q.size() > 0);
      k    = -1;
      w    = 16'h0;
      if (have) begin
        f = q[0];
        k = cyc - f.acc;
        w = {f.a, f.b};
      end
      es = 0;
      if (k >= 17 && k <= 17 + SD) es = (!BOTH && f.op) ? 5 : 4;
      else if (BOTH && k >= 18 + SD && k <= 18 + 2 * SD) es = 5;
      chk("busy", bus.busy, (k >= 0 && k < L) ? 1 : 0);
      chk("ser_out", bus.ser_out, (k >= 0 && k < 16) ? int'(w[15 - k]) : 0);
      chk("add_strobe", bus.add_strobe, (k == 16 && (BOTH || !f.op)) ? 1 : 0);
      chk("and_strobe", bus.and_strobe, (k == 16 && (BOTH || f.op)) ? 1 : 0);
      chk("sel", bus.sel, es);
      if (k == 18 + SD) held_res = f.res;
      if (bus.done) begin
        if (!have) chk("spurious_done", bus.done, 0);
        else begin
          chk("done_latency", k, L);
          held_res = f.res;
          held_and = f.res_and;
          void'(q.pop_front());
        end
      end else if (have && k == L) begin
        chk("done_missing", bus.done, 1);
        void'(q.pop_front());
      end
      chk("result", bus.result, held_res);
      chk("result_and", bus.result_and, held_and);
    end
  end

  initial begin
    bus.start  = 1'b0;
    bus.op_a   = 8'h00;
    bus.op_b   = 8'h00;
    bus.op_and = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    #2;
    rst = 1'b0;

    drive(1'b1, 8'h3C, 8'h5A, 1'b0);
    idle(L + 4);
    chk("add_3c5a", bus.result, 8'h96);

    drive(1'b1, 8'h3C, 8'h5A, 1'b1);
    idle(L + 4);
    chk("and_3c5a", bus.result, BOTH ? 8'h96 : 8'h18);
    chk("and_3c5a_second", bus.result_and, BOTH ? 8'h18 : 8'h00);

    drive(1'b1, 8'hFF, 8'h02, 1'b0);
    idle(L + 4);
    chk("add_wrap", bus.result, 8'h01);

    // re-pulses at relative edges 5 and 17 are ignored; the done-cycle start is taken
    drive(1'b1, 8'h11, 8'h22, 1'b0);
    for (int rel = 1; rel <= L; rel++)
      drive(rel == 5 || rel == 17, 8'($urandom), 8'($urandom), 1'b0);
    drive(1'b1, 8'h40, 8'h05, 1'b0);
    idle(L + 4);
    chk("back_to_back", bus.result, 8'h45);

    drive(1'b1, 8'hA5, 8'hC3, 1'b0);
    idle(8);
    async_reset();
    drive(1'b1, 8'h01, 8'h01, 1'b0);
    idle(L + 4);
    chk("after_reset", bus.result, 8'h02);

    repeat (400) drive($urandom_range(0, 3) == 0, 8'($urandom), 8'($urandom), 1'($urandom));
    idle(L + 5);
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
